mmio_timer: RTL and testbench

- Memory-mapped timer/interrupt source on the SoC data bus, i.e. the responder side of the core's memCe/memWr/memAddr/wtData/rdData port and the driver of the core's timer interrupt input (intr[0]).
- Holds a prescaled 32-bit up-counter and a compare register, and raises a level interrupt on match.
- Sits beside DataMem; the SoC steers accesses by address and ORs the read data.

---
 rtl/mmio_timer_pkg.sv | 40 ++++
 rtl/mmio_timer_if.sv | 20 ++
 rtl/mmio_timer_prescaler.sv | 34 +++
 rtl/mmio_timer.sv | 112 +++++++++++
 tb/tb_mmio_timer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped timer.
// Holds the register offsets, CTRL bit positions, reset values and the address decoder.
package mmio_timer_pkg;

    localparam logic [4:0] OFF_CTRL  = 5'h00;
    localparam logic [4:0] OFF_PRESC = 5'h04;
    localparam logic [4:0] OFF_COUNT = 5'h08;
    localparam logic [4:0] OFF_CMP   = 5'h0C;
    localparam logic [4:0] OFF_STAT  = 5'h10;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;
    localparam int CTRL_AR = 2;

    localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_PRESC,
        SEL_COUNT,
        SEL_CMP,
        SEL_STAT
    } sel_e;

    // Takes word-offset bits [4:2] and returns the selected register.
    function automatic sel_e decode(logic [2:0] w);
        logic [4:0] off;
        off = {w, 2'b00};
        unique case (1'b1)
            off == OFF_CTRL:  return SEL_CTRL;
            off == OFF_PRESC: return SEL_PRESC;
            off == OFF_COUNT: return SEL_COUNT;
            off == OFF_CMP:   return SEL_CMP;
            off == OFF_STAT:  return SEL_STAT;
            default:          return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// Data-bus port between the core (master) and the timer (slave).
// Signals: ce, we, addr and wtData come from the master; rdData and hit are returned by the slave.
interface mmio_timer_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wtData;
    logic [31:0] rdData;
    logic        hit;

    modport master (
        output ce, we, addr, wtData,
        input  rdData, hit
    );

    modport slave (
        input  ce, we, addr, wtData,
        output rdData, hit
    );
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Prescaler: produces a one-cycle tick once every presc_i+1 enabled cycles.
// Ports: clk, rst (async low), en_i, clr_i (restart), presc_i, tick_o.
module timer_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] presc_i,
    output logic         tick_o
);

    logic [W-1:0] pcnt_q;
    logic [W-1:0] pcnt_d;

    assign tick_o = en_i && (pcnt_q == presc_i);

    always_comb begin
        pcnt_d = pcnt_q + W'(1);
        if (!en_i || clr_i || tick_o) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer: prescaled 32-bit up-counter with compare and a level interrupt.
// Ports: clk, rst (async low), bus (slave side of the data bus), intimer (interrupt to the core).
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          PRESC_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    mmio_timer_if.slave  bus,
    output logic         intimer
);

    logic [2:0]         ctrl_q,  ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        cmp_q,   cmp_d;
    logic               pend_q,  pend_d;

    sel_e sel;
    logic wr;
    logic tick;
    logic match;
    logic unused_bits;

    // The window spans 32 bytes; offsets past STATUS hit but decode to nothing.
    assign bus.hit = bus.ce && (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign sel     = decode(bus.addr[4:2]);
    assign wr      = bus.ce && bus.we && bus.hit;

    assign unused_bits = ^{bus.addr[1:0], bus.wtData[31:3]};

    timer_prescaler #(.W(PRESC_W)) u_presc (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ctrl_q[CTRL_EN]),
        .clr_i   (wr && sel == SEL_PRESC),
        .presc_i (presc_q),
        .tick_o  (tick)
    );

    // The match check uses the registered COUNT and COMPARE, so it sees the values from before any write in this cycle.
    assign match   = tick && (count_q == cmp_q);
    assign intimer = pend_q && ctrl_q[CTRL_IE];

    always_comb begin
        bus.rdData = '0;
        if (bus.hit && !bus.we) begin
            unique case (sel)
                SEL_CTRL:  bus.rdData = {29'b0, ctrl_q};
                SEL_PRESC: bus.rdData = 32'(presc_q);
                SEL_COUNT: bus.rdData = count_q;
                SEL_CMP:   bus.rdData = cmp_q;
                SEL_STAT:  bus.rdData = {31'b0, pend_q};
                default:   bus.rdData = '0;
            endcase
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        pend_d  = pend_q;

        if (tick) begin
            if (!match) begin
                count_d = count_q + 32'd1;
            end else if (ctrl_q[CTRL_AR]) begin
                count_d = '0;
            end else begin
                ctrl_d[CTRL_EN] = 1'b0;
            end
        end

        // Bus writes come after the counter update so they take priority over it.
        if (wr) begin
            unique case (sel)
                SEL_CTRL:  ctrl_d  = bus.wtData[2:0];
                SEL_PRESC: presc_d = bus.wtData[PRESC_W-1:0];
                SEL_COUNT: count_d = bus.wtData;
                SEL_CMP:   cmp_d   = bus.wtData;
                SEL_STAT:  if (bus.wtData[0]) pend_d = 1'b0;
                default:   ;
            endcase
        end

        // A match beats a write-1-to-clear of PEND in the same cycle.
        if (match) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            count_q <= '0;
            cmp_q   <= CMP_RST;
            pend_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Testbench for mmio_timer.
// Runs a table of bus reads and writes, then directed sequences for races, counter wrap and reset.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] O_CTRL = 32'h00;
    localparam logic [31:0] O_PRS  = 32'h04;
    localparam logic [31:0] O_CNT  = 32'h08;
    localparam logic [31:0] O_CMP  = 32'h0C;
    localparam logic [31:0] O_STAT = 32'h10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic intimer;

    always #5 clk = ~clk;

    mmio_timer_if bus ();

    mmio_timer #(
        .BASE_ADDR (BASE),
        .PRESC_W   (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .intimer (intimer)
    );

    typedef struct {
        bit          wr;
        logic [31:0] off;
        logic [31:0] data;
        int          pre;
        logic [31:0] exp;
        bit          ehit;
        bit          eint;
        string       nm;
    } vec_t;

    vec_t tbl[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic add_w(logic [31:0] off, logic [31:0] d);
        vec_t v;
        v = '{1'b1, off, d, 0, 32'h0, 1'b0, 1'b0, "w"};
        tbl.push_back(v);
    endtask

    task automatic add_r(string nm, int pre, logic [31:0] off,
                         logic [31:0] e, bit eh, bit ei);
        vec_t v;
        v = '{1'b0, off, 32'h0, pre, e, eh, ei, nm};
        tbl.push_back(v);
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        bus.ce = 1'b1;
        bus.we = 1'b1;
        bus.addr = a;
        bus.wtData = d;
        @(posedge clk);
        #1;
        bus.ce = 1'b0;
        bus.we = 1'b0;
    endtask

    task automatic rd_chk(string nm, logic [31:0] a, logic [31:0] e,
                          bit eh, bit ei);
        bus.ce = 1'b1;
        bus.we = 1'b0;
        bus.addr = a;
        #1;
        chk({nm, ".rd"}, bus.rdData, e);
        chk({nm, ".hit"}, 32'(bus.hit), 32'(eh));
        chk({nm, ".int"}, 32'(intimer), 32'(ei));
        bus.ce = 1'b0;
    endtask

    initial begin
        // after reset
        add_r("rst_ctrl", 0, O_CTRL, 32'h0, 1, 0);
        add_r("rst_prs", 0, O_PRS, 32'h0, 1, 0);
        add_r("rst_cnt", 0, O_CNT, 32'h0, 1, 0);
        add_r("rst_cmp", 0, O_CMP, 32'hFFFF_FFFF, 1, 0);
        add_r("rst_stat", 0, O_STAT, 32'h0, 1, 0);
        // periodic, period 4
        add_w(O_PRS, 0);
        add_w(O_CMP, 3);
        add_w(O_CTRL, 7);
        add_r("per_c0", 0, O_CNT, 0, 1, 0);
        add_r("per_c1", 1, O_CNT, 1, 1, 0);
        add_r("per_c2", 1, O_CNT, 2, 1, 0);
        add_r("per_c3", 1, O_CNT, 3, 1, 0);
        add_r("per_nopend", 0, O_STAT, 0, 1, 0);
        add_r("per_pend", 1, O_STAT, 1, 1, 1);
        add_r("per_reload", 0, O_CNT, 0, 1, 1);
        add_r("per_period", 4, O_CNT, 0, 1, 1);
        add_w(O_CTRL, 0);
        add_r("per_stop", 0, O_CNT, 1, 1, 0);
        add_w(O_STAT, 1);
        add_r("per_clr", 0, O_STAT, 0, 1, 0);
        add_w(O_CNT, 0);
        // prescaled one-shot
        add_w(O_PRS, 2);
        add_w(O_CMP, 1);
        add_w(O_CTRL, 3);
        add_r("os_c0", 0, O_CNT, 0, 1, 0);
        add_r("os_c0b", 2, O_CNT, 0, 1, 0);
        add_r("os_c1", 1, O_CNT, 1, 1, 0);
        add_r("os_nopend", 2, O_STAT, 0, 1, 0);
        add_r("os_pend", 1, O_STAT, 1, 1, 1);
        add_r("os_en0", 0, O_CTRL, 2, 1, 1);
        add_r("os_hold", 0, O_CNT, 1, 1, 1);
        add_r("os_hold2", 3, O_CNT, 1, 1, 1);
        add_w(O_STAT, 1);
        add_r("os_clr", 0, O_STAT, 0, 1, 0);
        // address decode
        add_r("dec_14", 0, 32'h14, 0, 1, 0);
        add_r("dec_m4", 0, 32'hFFFF_FFFC, 0, 0, 0);
        add_w(32'h14, 32'hFFFF_FFFF);
        add_w(32'h20, 7);
        add_w(32'hFFFF_FFE0, 7);
        add_r("dec_ctrl", 0, O_CTRL, 2, 1, 0);
        add_r("dec_cmp", 0, O_CMP, 1, 1, 0);
        add_r("dec_cnt", 0, O_CNT, 1, 1, 0);
        add_r("dec_prs", 0, O_PRS, 2, 1, 0);

        bus.ce = 1'b0;
        bus.we = 1'b0;
        bus.addr = BASE;
        bus.wtData = '0;
        #3;
        chk("rst_hit", 32'(bus.hit), 0);
        chk("rst_rd", bus.rdData, 0);
        chk("rst_int", 32'(intimer), 0);
        #4;
        rst = 1'b1;
        cyc(1);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].pre);
            if (tbl[i].wr) begin
                wr(BASE + tbl[i].off, tbl[i].data);
            end else begin
                rd_chk(tbl[i].nm, BASE + tbl[i].off, tbl[i].exp,
                       tbl[i].ehit, tbl[i].eint);
            end
        end

        // match and STATUS clear in the same cycle
        wr(BASE + O_CTRL, 0);
        wr(BASE + O_PRS, 0);
        wr(BASE + O_CMP, 2);
        wr(BASE + O_CNT, 0);
        wr(BASE + O_CTRL, 5);
        cyc(2);
        wr(BASE + O_STAT, 1);
        rd_chk("race_set", BASE + O_STAT, 1, 1, 0);
        wr(BASE + O_STAT, 1);
        rd_chk("race_clr", BASE + O_STAT, 0, 1, 0);
        wr(BASE + O_CTRL, 0);

        // counter wrap and COUNT write during a tick
        wr(BASE + O_CMP, 5);
        wr(BASE + O_CNT, 32'hFFFF_FFFF);
        wr(BASE + O_CTRL, 1);
        rd_chk("wrap_pre", BASE + O_CNT, 32'hFFFF_FFFF, 1, 0);
        cyc(1);
        rd_chk("wrap_cnt", BASE + O_CNT, 0, 1, 0);
        rd_chk("wrap_stat", BASE + O_STAT, 0, 1, 0);
        wr(BASE + O_CNT, 9);
        rd_chk("wpri_cnt", BASE + O_CNT, 9, 1, 0);
        wr(BASE + O_CTRL, 0);
        rd_chk("wpri_inc", BASE + O_CNT, 10, 1, 0);

        // reset in the middle of counting
        wr(BASE + O_PRS, 1);
        wr(BASE + O_CMP, 100);
        wr(BASE + O_CTRL, 7);
        cyc(5);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        cyc(1);
        chk("mrst_hit", 32'(bus.hit), 0);
        rd_chk("mrst_ctrl", BASE + O_CTRL, 0, 1, 0);
        rd_chk("mrst_cnt", BASE + O_CNT, 0, 1, 0);
        rd_chk("mrst_cmp", BASE + O_CMP, 32'hFFFF_FFFF, 1, 0);
        rd_chk("mrst_prs", BASE + O_PRS, 0, 1, 0);
        cyc(3);
        rd_chk("mrst_idle", BASE + O_CNT, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
